// File: rtl/cv32e40x_rvfi_mem_collector.sv
// Collects a retiring instruction's LSU transfers into NMEM RVFI slots and emits one
// registered record per retire. Optional per-slot error tracking: CV32E40X_RVFI_MEM_ERR_EN.
package cv32e40x_rvfi_pkg;
    parameter int unsigned NMEM = 2;
endpackage

module cv32e40x_rvfi_mem_collector #(
    parameter int unsigned NMEM = cv32e40x_rvfi_pkg::NMEM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic                 op_we,
    input  logic [31:0]          op_addr,
    input  logic [3:0]           op_be,
    input  logic [31:0]          op_wdata,
    input  logic                 resp_valid,
    input  logic [31:0]          resp_rdata,
`ifdef CV32E40X_RVFI_MEM_ERR_EN
    input  logic                 resp_err,
    output logic [NMEM-1:0]      rvfi_mem_err,
`endif
    input  logic                 retire_valid,
    output logic                 retire_ready,
    input  logic [31:0]          retire_pc,
    input  logic                 kill,
    output logic                 rvfi_valid,
    output logic [31:0]          rvfi_pc_rdata,
    output logic [32*NMEM-1:0]   rvfi_mem_addr,
    output logic [4*NMEM-1:0]    rvfi_mem_rmask,
    output logic [4*NMEM-1:0]    rvfi_mem_wmask,
    output logic [32*NMEM-1:0]   rvfi_mem_rdata,
    output logic [32*NMEM-1:0]   rvfi_mem_wdata
);

    localparam int unsigned IW = $clog2(NMEM + 1);

    logic [IW-1:0] wr_idx_q, wr_idx_d, rsp_idx_q, rsp_idx_d;
    logic [31:0]   addr_q  [NMEM];
    logic [31:0]   addr_d  [NMEM];
    logic [3:0]    be_q    [NMEM];
    logic [3:0]    be_d    [NMEM];
    logic          we_q    [NMEM];
    logic          we_d    [NMEM];
    logic [31:0]   wdata_q [NMEM];
    logic [31:0]   wdata_d [NMEM];
    logic [31:0]   rdata_q [NMEM];
    logic [31:0]   rdata_d [NMEM];
`ifdef CV32E40X_RVFI_MEM_ERR_EN
    logic [NMEM-1:0] err_q, err_d;
    logic [NMEM-1:0] rvfi_err_q, rvfi_err_d;
`endif

    logic                rvfi_valid_q, rvfi_valid_d;
    logic [31:0]         rvfi_pc_q, rvfi_pc_d;
    logic [32*NMEM-1:0]  rvfi_addr_q, rvfi_addr_d;
    logic [4*NMEM-1:0]   rvfi_rmask_q, rvfi_rmask_d;
    logic [4*NMEM-1:0]   rvfi_wmask_q, rvfi_wmask_d;
    logic [32*NMEM-1:0]  rvfi_rdata_q, rvfi_rdata_d;
    logic [32*NMEM-1:0]  rvfi_wdata_q, rvfi_wdata_d;

    logic          op_fire, rsp_fire, ret_fire, rsp_err;
    logic [IW-1:0] op_slot;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always_comb begin
        op_ready     = (wr_idx_q < IW'(NMEM));
        retire_ready = (rsp_idx_q == wr_idx_q);
        op_fire      = op_valid && op_ready && !kill;
        rsp_fire     = resp_valid && (rsp_idx_q < wr_idx_q) && !kill;
        ret_fire     = retire_valid && retire_ready && !kill;
        // An op arriving with the retire belongs to the next instruction, so it lands in slot 0.
        op_slot      = ret_fire ? '0 : wr_idx_q;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        rsp_err      = resp_err;
`else
        rsp_err      = 1'b0;
`endif
    end

    always_comb begin
        wr_idx_d  = wr_idx_q;
        rsp_idx_d = rsp_idx_q;
        addr_d    = addr_q;
        be_d      = be_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        err_d     = err_q;
`endif
        if (kill) begin
            wr_idx_d  = '0;
            rsp_idx_d = '0;
            addr_d    = '{default: '0};
            be_d      = '{default: '0};
            we_d      = '{default: '0};
            wdata_d   = '{default: '0};
            rdata_d   = '{default: '0};
`ifdef CV32E40X_RVFI_MEM_ERR_EN
            err_d     = '0;
`endif
        end else begin
            if (rsp_fire) rsp_idx_d = rsp_idx_q + IW'(1);
            if (ret_fire) begin
                wr_idx_d  = '0;
                rsp_idx_d = '0;
            end
            if (op_fire) wr_idx_d = op_slot + IW'(1);
            for (int unsigned i = 0; i < NMEM; i++) begin
                if (rsp_fire && (IW'(i) == rsp_idx_q)) begin
                    rdata_d[i] = (we_q[i] || rsp_err) ? '0 : (resp_rdata & lane_mask(be_q[i]));
`ifdef CV32E40X_RVFI_MEM_ERR_EN
                    err_d[i]   = rsp_err;
`endif
                end
                if (op_fire && (IW'(i) == op_slot)) begin
                    addr_d[i]  = op_addr;
                    be_d[i]    = op_be;
                    we_d[i]    = op_we;
                    wdata_d[i] = op_wdata;
                    rdata_d[i] = '0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
                    err_d[i]   = 1'b0;
`endif
                end
            end
        end
    end

    always_comb begin
        rvfi_valid_d = ret_fire;
        rvfi_pc_d    = rvfi_pc_q;
        rvfi_addr_d  = rvfi_addr_q;
        rvfi_rmask_d = rvfi_rmask_q;
        rvfi_wmask_d = rvfi_wmask_q;
        rvfi_rdata_d = rvfi_rdata_q;
        rvfi_wdata_d = rvfi_wdata_q;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        rvfi_err_d   = rvfi_err_q;
`endif
        if (ret_fire) begin
            rvfi_pc_d    = retire_pc;
            rvfi_addr_d  = '0;
            rvfi_rmask_d = '0;
            rvfi_wmask_d = '0;
            rvfi_rdata_d = '0;
            rvfi_wdata_d = '0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
            rvfi_err_d   = '0;
`endif
            for (int unsigned i = 0; i < NMEM; i++) begin
                if (IW'(i) < wr_idx_q) begin
                    rvfi_addr_d[32*i +: 32] = addr_q[i];
                    rvfi_rmask_d[4*i +: 4]  = we_q[i] ? 4'b0 : be_q[i];
                    rvfi_wmask_d[4*i +: 4]  = we_q[i] ? be_q[i] : 4'b0;
                    rvfi_rdata_d[32*i +: 32] = rdata_q[i];
                    rvfi_wdata_d[32*i +: 32] = we_q[i] ? wdata_q[i] : 32'b0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
                    rvfi_err_d[i]           = err_q[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx_q     <= '0;
            rsp_idx_q    <= '0;
            addr_q       <= '{default: '0};
            be_q         <= '{default: '0};
            we_q         <= '{default: '0};
            wdata_q      <= '{default: '0};
            rdata_q      <= '{default: '0};
            rvfi_valid_q <= 1'b0;
            rvfi_pc_q    <= '0;
            rvfi_addr_q  <= '0;
            rvfi_rmask_q <= '0;
            rvfi_wmask_q <= '0;
            rvfi_rdata_q <= '0;
            rvfi_wdata_q <= '0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
            err_q        <= '0;
            rvfi_err_q   <= '0;
`endif
        end else begin
            wr_idx_q     <= wr_idx_d;
            rsp_idx_q    <= rsp_idx_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rvfi_valid_q <= rvfi_valid_d;
            rvfi_pc_q    <= rvfi_pc_d;
            rvfi_addr_q  <= rvfi_addr_d;
            rvfi_rmask_q <= rvfi_rmask_d;
            rvfi_wmask_q <= rvfi_wmask_d;
            rvfi_rdata_q <= rvfi_rdata_d;
            rvfi_wdata_q <= rvfi_wdata_d;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
            err_q        <= err_d;
            rvfi_err_q   <= rvfi_err_d;
`endif
        end
    end

    assign rvfi_valid     = rvfi_valid_q;
    assign rvfi_pc_rdata  = rvfi_pc_q;
    assign rvfi_mem_addr  = rvfi_addr_q;
    assign rvfi_mem_rmask = rvfi_rmask_q;
    assign rvfi_mem_wmask = rvfi_wmask_q;
    assign rvfi_mem_rdata = rvfi_rdata_q;
    assign rvfi_mem_wdata = rvfi_wdata_q;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
    assign rvfi_mem_err   = rvfi_err_q;
`endif

    // A response with nothing outstanding means the LSU failed to suppress it.
    resp_without_op: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid && (rsp_idx_q == wr_idx_q)));

endmodule

// File: tb/tb_cv32e40x_rvfi_mem_collector.sv
// Bench for cv32e40x_rvfi_mem_collector: directed vector table, reset/error sequences,
// and randomized traffic against a queue-based reference model.
module tb_cv32e40x_rvfi_mem_collector;

    localparam int unsigned NMEM = 2;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, op_valid, op_ready, op_we, resp_valid;
    logic [31:0]         op_addr, op_wdata, resp_rdata, retire_pc;
    logic [3:0]          op_be;
    logic                retire_valid, retire_ready, kill, rvfi_valid;
    logic [31:0]         rvfi_pc_rdata;
    logic [32*NMEM-1:0]  rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4*NMEM-1:0]   rvfi_mem_rmask, rvfi_mem_wmask;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
    logic                resp_err;
    logic [NMEM-1:0]     rvfi_mem_err;
`endif

    cv32e40x_rvfi_mem_collector #(.NMEM(NMEM)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_we(op_we), .op_addr(op_addr),
        .op_be(op_be), .op_wdata(op_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        .resp_err(resp_err), .rvfi_mem_err(rvfi_mem_err),
`endif
        .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_pc(retire_pc),
        .kill(kill),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic ov; logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;
        logic rv; logic [31:0] rd;
        logic tv; logic [31:0] pc; logic k;
        logic e_opr; logic e_rtr; logic e_val; logic [31:0] e_pc;
        logic [63:0] e_addr; logic [7:0] e_rm; logic [7:0] e_wm;
        logic [63:0] e_rd; logic [63:0] e_wd;
    } vec_t;

    function automatic vec_t mk(
        input logic ov, input logic we, input logic [31:0] addr, input logic [3:0] be,
        input logic [31:0] wd, input logic rv, input logic [31:0] rd,
        input logic tv, input logic [31:0] pc, input logic k,
        input logic e_opr, input logic e_rtr, input logic e_val, input logic [31:0] e_pc,
        input logic [63:0] e_addr, input logic [7:0] e_rm, input logic [7:0] e_wm,
        input logic [63:0] e_rd, input logic [63:0] e_wd);
        vec_t v;
        v.ov = ov; v.we = we; v.addr = addr; v.be = be; v.wd = wd;
        v.rv = rv; v.rd = rd; v.tv = tv; v.pc = pc; v.k = k;
        v.e_opr = e_opr; v.e_rtr = e_rtr; v.e_val = e_val; v.e_pc = e_pc;
        v.e_addr = e_addr; v.e_rm = e_rm; v.e_wm = e_wm; v.e_rd = e_rd; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic idle_inputs();
        op_valid = 1'b0; op_we = 1'b0; op_addr = '0; op_be = '0; op_wdata = '0;
        resp_valid = 1'b0; resp_rdata = '0; retire_valid = 1'b0; retire_pc = '0; kill = 1'b0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        resp_err = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the instruction's ops as a queue plus a count of responses seen.
    typedef struct {
        logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
        logic [31:0] rdata; logic err;
    } mop_t;
    mop_t               m_ops[$];
    int                 m_nresp;
    logic               e_val;
    logic [31:0]        e_pc;
    logic [32*NMEM-1:0] e_addr, e_rd, e_wd;
    logic [4*NMEM-1:0]  e_rm, e_wm;
    logic [NMEM-1:0]    e_err;

    task automatic model_reset();
        m_ops.delete(); m_nresp = 0;
        e_val = 1'b0; e_pc = '0; e_addr = '0; e_rd = '0; e_wd = '0;
        e_rm = '0; e_wm = '0; e_err = '0;
    endtask

    task automatic model_step();
        bit   room;
        bit   drained;
        bit   rerr;
        mop_t m;
        logic [31:0] rd;
        room    = (m_ops.size() < NMEM);
        drained = (m_nresp == m_ops.size());
        rerr    = 1'b0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        rerr    = resp_err;
`endif
        e_val = 1'b0;
        if (kill) begin
            m_ops.delete(); m_nresp = 0;
            return;
        end
        if (retire_valid && drained) begin
            e_val = 1'b1; e_pc = retire_pc;
            e_addr = '0; e_rd = '0; e_wd = '0; e_rm = '0; e_wm = '0; e_err = '0;
            foreach (m_ops[i]) begin
                e_addr[32*i +: 32] = m_ops[i].addr;
                e_rd[32*i +: 32]   = m_ops[i].rdata;
                e_wd[32*i +: 32]   = m_ops[i].we ? m_ops[i].wdata : 32'h0;
                e_rm[4*i +: 4]     = m_ops[i].we ? 4'h0 : m_ops[i].be;
                e_wm[4*i +: 4]     = m_ops[i].we ? m_ops[i].be : 4'h0;
                e_err[i]           = m_ops[i].err;
            end
            m_ops.delete(); m_nresp = 0;
        end else if (resp_valid && (m_nresp < m_ops.size())) begin
            m = m_ops[m_nresp];
            rd = '0;
            for (int b = 0; b < 4; b++)
                if (m.be[b]) rd = rd | (resp_rdata & (32'hFF << (8 * b)));
            m.rdata = (m.we || rerr) ? 32'h0 : rd;
            m.err   = rerr;
            m_ops[m_nresp] = m;
            m_nresp++;
        end
        if (op_valid && room) begin
            m.addr = op_addr; m.be = op_be; m.we = op_we; m.wdata = op_wdata;
            m.rdata = '0; m.err = 1'b0;
            m_ops.push_back(m);
        end
    endtask

    vec_t tbl[18];

    initial begin
        // ov we addr be wd | rv rd | tv pc k | opr rtr val pc addr rm wm rd wd
        tbl[0]  = mk(O,O,'0,'0,'0, O,'0, I,32'h100,O, I,I,I,32'h100,'0,'0,'0,'0,'0);
        tbl[1]  = mk(O,O,'0,'0,'0, O,'0, O,'0,O,      I,I,O,'0,'0,'0,'0,'0,'0);
        tbl[2]  = mk(I,O,32'h2000,4'b0011,'0, O,'0, O,'0,O, I,I,O,'0,'0,'0,'0,'0,'0);
        tbl[3]  = mk(O,O,'0,'0,'0, O,'0, I,32'h104,O, I,O,O,'0,'0,'0,'0,'0,'0);
        tbl[4]  = mk(O,O,'0,'0,'0, I,32'hDEADBEEF, I,32'h104,O, I,O,O,'0,'0,'0,'0,'0,'0);
        tbl[5]  = mk(O,O,'0,'0,'0, O,'0, I,32'h104,O, I,I,I,32'h104,
                     64'h0000_0000_0000_2000, 8'h03, 8'h00, 64'h0000_0000_0000_BEEF, '0);
        tbl[6]  = mk(I,I,32'h3000,4'hF,32'h12345678, O,'0, O,'0,O, I,I,O,'0,'0,'0,'0,'0,'0);
        tbl[7]  = mk(I,O,32'h3004,4'hF,'0, I,32'h55555555, O,'0,O, I,O,O,'0,'0,'0,'0,'0,'0);
        tbl[8]  = mk(I,I,32'h4000,4'hF,32'hAAAAAAAA, O,'0, I,32'h108,O, O,O,O,'0,'0,'0,'0,'0,'0);
        tbl[9]  = mk(O,O,'0,'0,'0, I,32'hCAFEF00D, I,32'h108,O, O,O,O,'0,'0,'0,'0,'0,'0);
        tbl[10] = mk(O,O,'0,'0,'0, O,'0, I,32'h108,O, O,I,I,32'h108,
                     64'h0000_3004_0000_3000, 8'hF0, 8'h0F, 64'hCAFEF00D_00000000,
                     64'h00000000_12345678);
        tbl[11] = mk(O,O,'0,'0,'0, O,'0, O,'0,O, I,I,O,'0,'0,'0,'0,'0,'0);
        tbl[12] = mk(I,O,32'h5000,4'hF,'0, O,'0, O,'0,O, I,I,O,'0,'0,'0,'0,'0,'0);
        tbl[13] = mk(I,O,32'h6000,4'hF,'0, O,'0, I,32'h10C,I, I,O,O,'0,'0,'0,'0,'0,'0);
        tbl[14] = mk(O,O,'0,'0,'0, O,'0, I,32'h110,O, I,I,I,32'h110,'0,'0,'0,'0,'0);
        tbl[15] = mk(I,O,32'h7000,4'b0001,'0, O,'0, I,32'h114,O, I,I,I,32'h114,'0,'0,'0,'0,'0);
        tbl[16] = mk(O,O,'0,'0,'0, I,32'h123456AB, O,'0,O, I,O,O,'0,'0,'0,'0,'0,'0);
        tbl[17] = mk(O,O,'0,'0,'0, O,'0, I,32'h118,O, I,I,I,32'h118,
                     64'h0000_0000_0000_7000, 8'h01, 8'h00, 64'h0000_0000_0000_00AB, '0);

        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset op_ready", 128'(op_ready), 128'(1'b1));
        chk("reset retire_ready", 128'(retire_ready), 128'(1'b1));
        chk("reset rvfi_valid", 128'(rvfi_valid), 128'(1'b0));
        chk("reset rvfi_mem_addr", 128'(rvfi_mem_addr), 128'(0));

        for (int n = 0; n < 18; n++) begin
            op_valid = tbl[n].ov; op_we = tbl[n].we; op_addr = tbl[n].addr;
            op_be = tbl[n].be; op_wdata = tbl[n].wd;
            resp_valid = tbl[n].rv; resp_rdata = tbl[n].rd;
            retire_valid = tbl[n].tv; retire_pc = tbl[n].pc; kill = tbl[n].k;
            #1;
            chk($sformatf("v%0d op_ready", n), 128'(op_ready), 128'(tbl[n].e_opr));
            chk($sformatf("v%0d retire_ready", n), 128'(retire_ready), 128'(tbl[n].e_rtr));
            tick();
            chk($sformatf("v%0d rvfi_valid", n), 128'(rvfi_valid), 128'(tbl[n].e_val));
            if (tbl[n].e_val) begin
                chk($sformatf("v%0d pc", n), 128'(rvfi_pc_rdata), 128'(tbl[n].e_pc));
                chk($sformatf("v%0d addr", n), 128'(rvfi_mem_addr), 128'(tbl[n].e_addr));
                chk($sformatf("v%0d rmask", n), 128'(rvfi_mem_rmask), 128'(tbl[n].e_rm));
                chk($sformatf("v%0d wmask", n), 128'(rvfi_mem_wmask), 128'(tbl[n].e_wm));
                chk($sformatf("v%0d rdata", n), 128'(rvfi_mem_rdata), 128'(tbl[n].e_rd));
                chk($sformatf("v%0d wdata", n), 128'(rvfi_mem_wdata), 128'(tbl[n].e_wd));
            end
        end

        // Sync reset while slots are full with a response still outstanding.
        idle_inputs();
        op_valid = 1'b1; op_addr = 32'h8000; op_be = 4'hF;
        tick();
        op_addr = 32'h8004; resp_valid = 1'b1; resp_rdata = 32'h11;
        tick();
        idle_inputs();
        chk("full op_ready", 128'(op_ready), 128'(1'b0));
        retire_valid = 1'b1; retire_pc = 32'h200; rst_n = 1'b0;
        tick();
        chk("midreset rvfi_valid", 128'(rvfi_valid), 128'(1'b0));
        chk("midreset pc", 128'(rvfi_pc_rdata), 128'(0));
        chk("midreset op_ready", 128'(op_ready), 128'(1'b1));
        chk("midreset retire_ready", 128'(retire_ready), 128'(1'b1));
        rst_n = 1'b1; retire_pc = 32'h204;
        tick();
        chk("postreset rvfi_valid", 128'(rvfi_valid), 128'(1'b1));
        chk("postreset pc", 128'(rvfi_pc_rdata), 128'(32'h204));
        chk("postreset addr", 128'(rvfi_mem_addr), 128'(0));
        idle_inputs();
        tick();

`ifdef CV32E40X_RVFI_MEM_ERR_EN
        op_valid = 1'b1; op_addr = 32'h9000; op_be = 4'hF;
        tick();
        idle_inputs();
        resp_valid = 1'b1; resp_rdata = 32'hFFFFFFFF; resp_err = 1'b1;
        tick();
        idle_inputs();
        retire_valid = 1'b1; retire_pc = 32'h300;
        tick();
        idle_inputs();
        chk("err rvfi_mem_err", 128'(rvfi_mem_err), 128'(2'b01));
        chk("err rdata", 128'(rvfi_mem_rdata), 128'(0));
        chk("err rmask", 128'(rvfi_mem_rmask), 128'(8'h0F));
`endif

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            op_valid     = 1'($urandom_range(0, 1));
            op_we        = 1'($urandom_range(0, 1));
            op_addr      = $urandom;
            op_be        = 4'($urandom);
            op_wdata     = $urandom;
            resp_valid   = (m_nresp < m_ops.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
            resp_rdata   = $urandom;
            retire_valid = 1'($urandom_range(0, 1));
            retire_pc    = $urandom;
            kill         = ($urandom_range(0, 15) == 0);
`ifdef CV32E40X_RVFI_MEM_ERR_EN
            resp_err     = ($urandom_range(0, 3) == 0);
`endif
            #1;
            chk($sformatf("r%0d op_ready", c), 128'(op_ready), 128'(m_ops.size() < NMEM));
            chk($sformatf("r%0d retire_ready", c), 128'(retire_ready),
                128'(m_nresp == m_ops.size()));
            model_step();
            tick();
            chk($sformatf("r%0d rvfi_valid", c), 128'(rvfi_valid), 128'(e_val));
            chk($sformatf("r%0d pc", c), 128'(rvfi_pc_rdata), 128'(e_pc));
            chk($sformatf("r%0d addr", c), 128'(rvfi_mem_addr), 128'(e_addr));
            chk($sformatf("r%0d rmask", c), 128'(rvfi_mem_rmask), 128'(e_rm));
            chk($sformatf("r%0d wmask", c), 128'(rvfi_mem_wmask), 128'(e_wm));
            chk($sformatf("r%0d rdata", c), 128'(rvfi_mem_rdata), 128'(e_rd));
            chk($sformatf("r%0d wdata", c), 128'(rvfi_mem_wdata), 128'(e_wd));
`ifdef CV32E40X_RVFI_MEM_ERR_EN
            chk($sformatf("r%0d err", c), 128'(rvfi_mem_err), 128'(e_err));
`endif
        end

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40x_rvfi_mem_collector.md
Name: cv32e40x_rvfi_mem_collector

Overview:
- Producer side of the RVFI memory fields: collects a retiring instruction's LSU transfers and response data into NMEM slots.
- On retire, emits one packed RVFI record: rvfi_valid, rvfi_pc_rdata, rvfi_mem_addr/rmask/wmask/rdata/wdata. This is the same slot layout that trace and consumer logic expect.
- Sits between the LSU/writeback stage and RVFI consumers.

Parameters:
- NMEM, cv32e40x_rvfi_pkg::NMEM, number of memory-operation slots per instruction (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  memory operation issued by LSU
- op_ready  out  1  slot available for op
- op_we  in  1  1=store, 0=load
- op_addr  in  32  byte address
- op_be  in  4  byte enables
- op_wdata  in  32  store data
- resp_valid  in  1  in-order response for oldest outstanding op
- resp_rdata  in  32  load data
- retire_valid  in  1  instruction owning collected ops retires
- retire_ready  out  1  all responses received
- retire_pc  in  32  PC of retiring instruction
- kill  in  1  discard collected ops (instruction flushed)
- rvfi_valid  out  1  record valid (1-cycle pulse)
- rvfi_pc_rdata  out  32
- rvfi_mem_addr  out  32*NMEM
- rvfi_mem_rmask  out  4*NMEM
- rvfi_mem_wmask  out  4*NMEM
- rvfi_mem_rdata  out  32*NMEM
- rvfi_mem_wdata  out  32*NMEM

Behaviour:
- Reset (rst_n low at posedge): all rvfi_* outputs 0. Slot count, outstanding count and all slots clear. op_ready=1, retire_ready=1.
- Slot state: wr_idx (ops accepted, 0..NMEM) and rsp_idx (responses received, 0..wr_idx). Both are $clog2(NMEM+1) bits; no wrap.
- op_ready = (wr_idx < NMEM).
  - Accept on op_valid && op_ready: slot[wr_idx] <= {addr, be, we, wdata}; wr_idx++.
- resp_valid with rsp_idx < wr_idx: slot[rsp_idx].rdata <= resp_rdata with non-enabled byte lanes zeroed; rsp_idx++.
  - Store responses are consumed the same way; their rdata is discarded (stays 0).
  - resp_valid with rsp_idx == wr_idx is ignored, and a simulation assertion fires.
- retire_ready = (rsp_idx == wr_idx).
- Retire handshake (retire_valid && retire_ready && !kill) registers, at the next edge:
  - rvfi_valid=1, rvfi_pc_rdata=retire_pc.
  - For each slot i < wr_idx: addr=slot.addr; rmask=be if load else 0; wmask=be if store else 0; rdata; wdata=store data if store else 0.
  - Slots i >= wr_idx: all fields 0.
  - The same edge clears wr_idx and rsp_idx.
- rvfi_valid is a single-cycle pulse. The other rvfi_* outputs hold until the next record.
- Zero-memop instruction: retire accepted immediately (wr_idx=0); all mask/data outputs 0.
- Op and retire in the same cycle: the op belongs to the next instruction. It is written to slot 0 and wr_idx=1 after the edge; rvfi outputs are built from the pre-edge slots.
- Response and op in the same cycle: both take effect.
- Response in the retire cycle: impossible by construction, because retire_ready requires no outstanding responses.
- kill: clears wr_idx, rsp_idx and slots at the next edge; no rvfi_valid.
  - kill has priority over retire and over an op in the same cycle; that op is dropped.
  - Outstanding responses arriving after kill are the LSU's responsibility to suppress; if they arrive, they are ignored per the rule above.
- Sync reset mid-collection: same as reset; any pending rvfi_valid pulse is suppressed.

Optional Feature:
- Macro CV32E40X_RVFI_MEM_ERR_EN.
- Defined:
  - Adds input resp_err (1) and output rvfi_mem_err (NMEM), reset 0.
  - resp_err with an accepted response sets err[rsp_idx]; rvfi_mem_err is emitted with the record.
  - An erroring load's rdata is forced to 0.
- Undefined: ports absent; all responses are treated as OK.

Test Plan:
- Reset, then retire_pc=0x100 with no ops -> next cycle rvfi_valid=1, pc=0x100, all masks/data 0; rvfi_valid=0 the cycle after.
- Load addr 0x2000, be=4'b0011, resp 0xDEADBEEF, retire pc=0x104 -> slot0 addr=0x2000, rmask=0011, rdata=0x0000BEEF, wmask=0.
- NMEM=2: store 0x3000 be=1111 wdata=0x12345678, then load 0x3004 be=1111; third op_valid -> op_ready=0. Retire held until 2nd resp 0xCAFEF00D -> slot0 wmask=1111/wdata=0x12345678; slot1 rmask=1111/rdata=0xCAFEF00D.
- Load issued, retire_valid asserted before resp -> retire_ready=0, no rvfi_valid; resp arrives -> retire_ready=1, rvfi_valid next cycle.
- kill asserted with retire_valid and op_valid in the same cycle -> no rvfi_valid, op dropped; next retire with no ops -> all masks 0.
- With CV32E40X_RVFI_MEM_ERR_EN: load resp_err=1, rdata=0xFFFFFFFF -> rvfi_mem_err[0]=1, rdata slot0=0.
